// File: rtl/uart_tx_packetizer.sv
// Buffers channel-tagged samples and frames each one as a 5-byte packet
// (sync, ch/seq, hi, lo, checksum) for the UART transmitter handshake.
module uart_tx_packetizer #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned FIFO_AW   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] sample_in,
    input  logic [1:0]  sample_ch,
    input  logic        sample_valid,
    output logic        sample_ready,
    input  logic        ready_to_send,
    output logic [7:0]  tx_in,
    output logic        tx_en,
    output logic        frame_busy,
    output logic [7:0]  drop_count
);

    localparam int unsigned DEPTH = 2 ** FIFO_AW;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STROBE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [17:0]      mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr, rd_ptr;
    logic             full, empty, push, pop;
    logic [17:0]      hold_q;
    logic [2:0]       idx_q, idx_d;
    logic [3:0]       seq_q, seq_d;
    logic [7:0]       tx_in_d;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                   (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign sample_ready = !full;
    assign push         = sample_valid && !full;
    assign frame_busy   = (state_q != IDLE);

    function automatic logic [7:0] frame_byte(
        input logic [2:0]  i,
        input logic [17:0] h,
        input logic [3:0]  s
    );
        logic [7:0] b1;
        logic [7:0] r;
        b1 = {s, 2'b00, h[17:16]};
        r  = SYNC_BYTE;
        case (i)
            3'd1:    r = b1;
            3'd2:    r = h[15:8];
            3'd3:    r = h[7:0];
            3'd4:    r = b1 + h[15:8] + h[7:0];
            default: r = SYNC_BYTE;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        seq_d   = seq_q;
        tx_in_d = tx_in;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    idx_d   = 3'd0;
                    tx_in_d = SYNC_BYTE;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (ready_to_send) state_d = STROBE;
            end
            STROBE: state_d = WAIT_BUSY;
            WAIT_BUSY: begin
                if (!ready_to_send) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (ready_to_send) begin
                    if (idx_q == 3'd4) begin
                        seq_d   = seq_q + 4'd1;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        tx_in_d = frame_byte(idx_q + 3'd1, hold_q, seq_q);
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            idx_q      <= '0;
            seq_q      <= '0;
            hold_q     <= '0;
            tx_in      <= '0;
            tx_en      <= 1'b0;
            drop_count <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            seq_q   <= seq_d;
            tx_in   <= tx_in_d;
            tx_en   <= (state_d == STROBE);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            // holding register keeps the frame in flight independent of FIFO writes
            if (pop) begin
                hold_q <= mem[rd_ptr[FIFO_AW-1:0]];
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (sample_valid && full && drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[FIFO_AW-1:0]] <= {sample_ch, sample_in};
    end

endmodule

// File: tb/tb_uart_tx_packetizer.sv
// Bench for uart_tx_packetizer: vector table, random bursts against a
// frame-level model, and hand sequences for stall/overflow/reset cases.
module tb_uart_tx_packetizer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] sample_in;
    logic [1:0]  sample_ch;
    logic        sample_valid;
    logic        sample_ready;
    logic        ready_to_send;
    logic [7:0]  tx_in;
    logic        tx_en;
    logic        frame_busy;
    logic [7:0]  drop_count;

    uart_tx_packetizer #(
        .SYNC_BYTE(8'hA5),
        .FIFO_AW  (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_ch    (sample_ch),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .ready_to_send(ready_to_send),
        .tx_in        (tx_in),
        .tx_en        (tx_en),
        .frame_busy   (frame_busy),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  ch;
        logic [39:0] bytes;
    } vec_t;

    vec_t       tbl [5];
    logic [7:0] cap_q [$];
    logic [7:0] exp_q [$];
    int         n_checks = 0;
    int         n_pass = 0;
    int         uart_cnt = 0;
    int         viol = 0;
    int         seq_m = 0;
    bit         hold_busy = 0;
    bit         rand_busy = 0;
    bit         prev_en = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, want);
    endtask

    // one clock: sample after the edge, then run the transmitter model
    task automatic tick();
        @(posedge clk);
        #1;
        if (tx_en) begin
            cap_q.push_back(tx_in);
            if (prev_en) viol++;
            uart_cnt = rand_busy ? int'($urandom_range(25, 2)) : 21;
        end else if (uart_cnt > 0) begin
            uart_cnt--;
        end
        prev_en = tx_en;
        ready_to_send = !hold_busy && (uart_cnt == 0);
    endtask

    task automatic push(input logic [15:0] d, input logic [1:0] c);
        sample_in    = d;
        sample_ch    = c;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    function automatic void add_frame(input int d, input int c);
        int b1, hi, lo;
        b1 = seq_m * 16 + c;
        hi = d / 256;
        lo = d % 256;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(b1));
        exp_q.push_back(8'(hi));
        exp_q.push_back(8'(lo));
        exp_q.push_back(8'((b1 + hi + lo) % 256));
        seq_m = (seq_m + 1) % 16;
    endfunction

    task automatic drain(input string name, input int n, input int limit);
        int t;
        t = 0;
        while ((cap_q.size() < n || frame_busy) && t < limit) begin
            tick();
            t++;
        end
        check({name, "_timeout"}, (t < limit) ? 1 : 0, 1);
    endtask

    task automatic compare_stream(input string name);
        check({name, "_len"}, cap_q.size(), exp_q.size());
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
            check({name, "_byte"}, cap_q[i], exp_q[i]);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        sample_valid = 1'b0;
        tick();
        reset = 1'b0;
        cap_q.delete();
        exp_q.delete();
        hold_busy     = 0;
        uart_cnt      = 0;
        ready_to_send = 1'b1;
        seq_m         = 0;
        prev_en       = 0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t, lat, nfr, en_cnt, unstable, busy_cnt;
        logic [7:0] b;
        reset         = 1'b1;
        sample_valid  = 1'b0;
        sample_in     = '0;
        sample_ch     = '0;
        ready_to_send = 1'b1;

        tbl[0] = '{16'h1234, 2'd1, 40'hA5_01_12_34_47};
        tbl[1] = '{16'hFFFF, 2'd2, 40'hA5_12_FF_FF_10};
        tbl[2] = '{16'h0000, 2'd3, 40'hA5_23_00_00_23};
        tbl[3] = '{16'h8001, 2'd0, 40'hA5_30_80_01_B1};
        tbl[4] = '{16'hABCD, 2'd1, 40'hA5_41_AB_CD_B9};

        tick();
        do_reset();
        check("reset_tx_in", tx_in, 8'h00);
        check("reset_tx_en", tx_en, 0);
        check("reset_busy", frame_busy, 0);
        check("reset_drops", drop_count, 0);
        check("reset_ready", sample_ready, 1);

        for (int v = 0; v < 5; v++) begin
            cap_q.delete();
            push(tbl[v].data, tbl[v].ch);
            lat = 0;
            while (!tx_en && lat < 10) begin
                tick();
                lat++;
            end
            check("first_strobe_latency", lat, 2);
            drain("vec", 5, 2000);
            check("vec_len", cap_q.size(), 5);
            for (int i = 0; i < 5 && i < cap_q.size(); i++)
                check("vec_byte", cap_q[i], tbl[v].bytes[39-8*i -: 8]);
            seq_m++;
        end

        rand_busy = 1;
        cap_q.delete();
        exp_q.delete();
        nfr = 0;
        while (nfr < 12) begin
            int nb;
            nb = $urandom_range(4, 1);
            for (int k = 0; k < nb; k++) begin
                logic [15:0] d;
                logic [1:0]  c;
                d = 16'($urandom);
                c = 2'($urandom);
                check("rand_ready", sample_ready, 1);
                add_frame(d, c);
                push(d, c);
                nfr++;
            end
            drain("rand", exp_q.size(), 6000);
            repeat ($urandom_range(5, 0)) tick();
        end
        compare_stream("rand");
        if (cap_q.size() > 56) begin
            b = cap_q[56];
            check("seq_wrap", b[7:4], 0);
        end else begin
            check("seq_wrap_len", cap_q.size(), 57);
        end
        rand_busy = 0;

        cap_q.delete();
        exp_q.delete();
        hold_busy     = 1;
        ready_to_send = 1'b0;
        add_frame(16'hBEEF, 2);
        push(16'hBEEF, 2'd2);
        tick();
        en_cnt   = 0;
        unstable = 0;
        repeat (50) begin
            tick();
            if (tx_en) en_cnt++;
            if (tx_in !== 8'hA5) unstable++;
        end
        check("stall_no_strobe", en_cnt, 0);
        check("stall_tx_in_stable", unstable, 0);
        check("stall_busy", frame_busy, 1);
        hold_busy     = 0;
        uart_cnt      = 0;
        ready_to_send = 1'b1;
        tick();
        check("stall_release_strobe", tx_en, 1);
        drain("stall", exp_q.size(), 2000);
        compare_stream("stall");

        cap_q.delete();
        exp_q.delete();
        hold_busy     = 1;
        ready_to_send = 1'b0;
        for (int i = 0; i < 7; i++) begin
            check("ovf_ready", sample_ready, (i < 5) ? 1 : 0);
            if (i < 5) add_frame(16'h1000 + i, i % 4);
            push(16'(16'h1000 + i), 2'(i % 4));
        end
        check("ovf_full", sample_ready, 0);
        check("ovf_drops", drop_count, 2);

        hold_busy     = 0;
        uart_cnt      = 0;
        ready_to_send = 1'b1;
        t = 0;
        while (frame_busy && t < 1000) begin
            tick();
            t++;
        end
        check("pop_wait_timeout", (t < 1000) ? 1 : 0, 1);
        sample_in    = 16'hDEAD;
        sample_ch    = 2'd3;
        sample_valid = 1'b1;
        check("pop_push_ready", sample_ready, 0);
        tick();
        sample_valid = 1'b0;
        check("pop_push_drop", drop_count, 3);
        check("after_pop_ready", sample_ready, 1);
        add_frame(16'h7777, 1);
        push(16'h7777, 2'd1);
        check("after_pop_drops", drop_count, 3);
        drain("ovf", exp_q.size(), 5000);
        compare_stream("ovf");

        hold_busy     = 1;
        ready_to_send = 1'b0;
        sample_in     = 16'h0F0F;
        sample_valid  = 1'b1;
        repeat (310) tick();
        sample_valid = 1'b0;
        check("drop_saturate", drop_count, 255);

        do_reset();
        check("reset2_drops", drop_count, 0);
        check("reset2_ready", sample_ready, 1);
        push(16'h5A5A, 2'd3);
        t = 0;
        while (cap_q.size() < 3 && t < 1000) begin
            tick();
            t++;
        end
        check("midframe_timeout", (t < 1000) ? 1 : 0, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_reset_tx_en", tx_en, 0);
        check("mid_reset_busy", frame_busy, 0);
        check("mid_reset_ready", sample_ready, 1);
        uart_cnt      = 0;
        ready_to_send = 1'b1;
        busy_cnt      = 0;
        repeat (5) begin
            tick();
            if (frame_busy) busy_cnt++;
        end
        check("fifo_empty_after_reset", busy_cnt, 0);
        cap_q.delete();
        exp_q.delete();
        seq_m = 0;
        add_frame(16'h0102, 0);
        push(16'h0102, 2'd0);
        drain("fresh", exp_q.size(), 2000);
        compare_stream("fresh");
        if (cap_q.size() > 1) check("fresh_seq", cap_q[1], 8'h00);
        else check("fresh_seq_len", cap_q.size(), 5);

        check("no_back_to_back_tx_en", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_packetizer.md
Name: uart_tx_packetizer

Overview:
- Upstream feeder for the UART transmitter.
- Accepts 16-bit acoustic samples tagged with a 2-bit channel and buffers them in a small FIFO.
- Frames each sample as a 5-byte packet: sync, channel/sequence, sample hi, sample lo, checksum.
- Hands the packet bytes one at a time to the UART transmitter using its tx_en / ready_to_send handshake.

Parameters:
SYNC_BYTE, 8'hA5, first byte of every frame
FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW = 4 entries

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
sample_in  input  16  sample data
sample_ch  input  2  channel tag of sample_in
sample_valid  input  1  sample_in/sample_ch valid this cycle
sample_ready  output  1  FIFO not full; a sample is accepted when sample_valid && sample_ready
ready_to_send  input  1  from UART transmitter: idle, may accept a byte
tx_in  output  8  byte to transmitter
tx_en  output  1  one-cycle start strobe to transmitter
frame_busy  output  1  a frame is in progress (state != IDLE)
drop_count  output  8  saturating count of samples lost to FIFO full

Behaviour:
- Reset (clk edge with reset=1) sets:
  - tx_in=0, tx_en=0, frame_busy=0, drop_count=0, sample_ready=1.
  - FIFO empty; seq=0; state=IDLE.
  - Reset mid-frame abandons the frame and discards FIFO contents.
- FIFO behaviour:
  - 4 entries of {ch[1:0], data[15:0]}.
  - sample_ready = !full, derived from registered pointers.
  - Push on sample_valid && sample_ready.
  - sample_valid && !sample_ready drops the sample and increments drop_count, saturating at 255.
  - Simultaneous pop and valid while full: the push is still dropped, because sample_ready was already 0 that cycle.
  - Pointers are FIFO_AW+1 bits and wrap naturally.
- Frame format:
  - B0 = SYNC_BYTE
  - B1 = {seq[3:0], 2'b00, ch[1:0]}
  - B2 = data[15:8]
  - B3 = data[7:0]
  - B4 = (B1 + B2 + B3) mod 256; SYNC_BYTE is excluded from the sum.
- State machine; byte index idx counts 0..4:
  - IDLE: if FIFO not empty, pop the head into a holding register, set idx=0 -> LOAD.
  - LOAD: drive tx_in = byte[idx]; tx_in stays stable from here until the next LOAD. If ready_to_send=1 -> STROBE, else remain.
  - STROBE: tx_en=1 for exactly this one cycle -> WAIT_BUSY.
  - WAIT_BUSY: wait for ready_to_send=0, meaning the transmitter has accepted the byte -> WAIT_DONE.
  - WAIT_DONE: wait for ready_to_send=1.
    - If idx<4: idx++ -> LOAD.
    - If idx==4: seq++ (wraps 15->0) -> IDLE.
- Latency and pacing:
  - From IDLE with a non-empty FIFO and transmitter idle, the first tx_en is asserted 2 cycles after the pop cycle.
  - Each subsequent byte is strobed 2 cycles after ready_to_send returns high.
  - Back-to-back frames have a 1-cycle IDLE gap.
- Outputs:
  - tx_en is registered; it is never asserted outside STROBE and never for 2 consecutive cycles.
  - frame_busy = 1 in every state except IDLE.
- FIFO pushes continue during frame transmission. The holding register isolates the frame in flight from FIFO writes.

Test Plan:
- Single frame: reset, push sample 0x1234 ch=1. Transmitter model with ready_to_send dropping 1 cycle after tx_en and returning 20 cycles later -> bytes A5, 01, 12, 34, 47 in order; exactly five 1-cycle tx_en pulses; frame_busy falls after the last byte.
- Checksum wrap and sequence: second frame 0xFFFF ch=2 -> bytes A5, 12, FF, FF, 10. After 16 frames, B1 seq field returns to 0.
- Overflow: hold the transmitter busy (ready_to_send=0), push 7 samples on consecutive cycles -> 4 accepted (one moves into the holding register on a non-empty FIFO, so accept 5 if IDLE pops); sample_ready=0 while full; drop_count equals pushes minus accepted. Saturation check: 300 forced drops -> drop_count=255.
- Simultaneous pop and push at full: FIFO full, release the transmitter so IDLE pops in the same cycle as sample_valid=1 -> that sample is dropped (drop_count+1); the next cycle's push is accepted.
- Stalled handshake: ready_to_send held 0 during LOAD for 50 cycles -> no tx_en, tx_in stable. Release -> tx_en 1 cycle later in STROBE.
- Reset mid-frame: assert reset after B2 is strobed -> next cycle tx_en=0, frame_busy=0, FIFO empty, seq=0. Next pushed sample starts a fresh frame with B0=A5, seq=0.
